// File: rtl/shift_seq_ctrl.sv
// Framed WIDTH-bit shift sequencer: parallel-load/MSB-first transmit or serial receive into dout.
// A request takes WIDTH+2 cycles from acceptance back to IDLE; start is ignored while busy, abort cancels.
module shift_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             mode_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)            state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shreg, bit counter, latched mode and the receive result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      dout   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            mode_q <= mode;
            cnt    <= '0;
            shreg  <= mode ? '0 : din;
          end
        end
        SHIFT: begin
          if (abort) begin
            cnt <= '0;
          end else begin
            shreg <= {shreg[WIDTH-2:0], mode_q ? serial_in : 1'b0};
            if (cnt == LAST) begin
              cnt <= '0;
              if (mode_q) dout <= {shreg[WIDTH-2:0], serial_in};
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign serial_valid = (state == SHIFT) && !mode_q;
  assign serial_out   = serial_valid & shreg[WIDTH-1];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: transfer-level model checked every cycle plus literal checks of the directed scenarios.
module tb_shift_seq_ctrl;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic         abort;
  logic [W-1:0] din;
  logic         serial_in;
  logic         serial_out;
  logic         serial_valid;
  logic [W-1:0] dout;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .abort        (abort),
    .din          (din),
    .serial_in    (serial_in),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .dout         (dout),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k is the cycle index within a transfer (0 = idle, 1..W shifting, W+1 done).
  int           m_k = 0;
  logic         m_mode = 1'b0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_rx = '0;
  logic [W-1:0] m_dout = '0;
  logic         armed = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      m_k    = 0;
      m_dout = '0;
      armed  = 1'b1;
    end else if (m_k == 0) begin
      if (start && !abort) begin
        m_k    = 1;
        m_mode = mode;
        m_word = din;
        m_rx   = '0;
      end
    end else if (m_k <= W) begin
      if (abort) begin
        m_k = 0;
      end else begin
        if (m_mode) m_rx[W-m_k] = serial_in;
        m_k++;
        if (m_k == W + 1 && m_mode) m_dout = m_rx;
      end
    end else begin
      m_k = 0;
    end
  end

  always @(negedge clk) begin
    logic exp_sv;
    logic exp_so;
    if (armed) begin
      exp_sv = (m_k >= 1) && (m_k <= W) && !m_mode;
      exp_so = exp_sv ? m_word[W-m_k] : 1'b0;
      chk("model_busy", {31'd0, busy}, {31'd0, m_k != 0});
      chk("model_done", {31'd0, done}, {31'd0, m_k == W + 1});
      chk("model_serial_valid", {31'd0, serial_valid}, {31'd0, exp_sv});
      chk("model_serial_out", {31'd0, serial_out}, {31'd0, exp_so});
      chk("model_dout", {28'd0, dout}, {28'd0, m_dout});
    end
  end

  task automatic step(input logic s, input logic m, input logic a,
                      input logic [W-1:0] d, input logic si);
    rst_n = 1'b1; start = s; mode = m; abort = a; din = d; serial_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_step();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; din = '0; serial_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] rxbits;

    reset_step();
    reset_step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sv", {31'd0, serial_valid}, 32'd0);
    chk("reset_so", {31'd0, serial_out}, 32'd0);
    chk("reset_dout", {28'd0, dout}, 32'd0);

    // Transmit 1011
    pat = 4'b1011;
    step(1'b1, 1'b0, 1'b0, 4'b1011, 1'b0);
    for (int k = 1; k <= W; k++) begin
      chk("tx1_so", {31'd0, serial_out}, {31'd0, pat[W-k]});
      chk("tx1_sv", {31'd0, serial_valid}, 32'd1);
      idle_step();
    end
    chk("tx1_done", {31'd0, done}, 32'd1);
    chk("tx1_dout", {28'd0, dout}, 32'd0);
    idle_step();
    chk("tx1_idle", {31'd0, busy}, 32'd0);

    // Receive 0,1,1,0
    rxbits = 4'b0110;
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 1; k <= W; k++) begin
      chk("rx1_sv", {31'd0, serial_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, '0, rxbits[W-k]);
    end
    chk("rx1_done", {31'd0, done}, 32'd1);
    chk("rx1_dout", {28'd0, dout}, 32'h6);
    idle_step();

    // Start held while busy
    pat = 4'b1000;
    step(1'b1, 1'b0, 1'b0, 4'b1000, 1'b0);
    for (int k = 1; k <= W + 1; k++) begin
      if (k <= W) chk("busy_so", {31'd0, serial_out}, {31'd0, pat[W-k]});
      else        chk("busy_done", {31'd0, done}, 32'd1);
      step(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0);
    end
    chk("busy_c6_idle", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0);
    for (int k = 1; k <= W; k++) begin
      chk("busy2_so", {31'd0, serial_out}, 32'd1);
      idle_step();
    end
    chk("busy2_done", {31'd0, done}, 32'd1);
    idle_step();

    // Abort in cycle 2 of a receive
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, '0, 1'b1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dout", {28'd0, dout}, 32'h6);
    idle_step();

    // Abort together with start in IDLE
    step(1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
    chk("abort_start_busy", {31'd0, busy}, 32'd0);

    // Abort on the last shift cycle of a receive
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 1; k < W; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, '0, 1'b1);
    chk("abort_last_done", {31'd0, done}, 32'd0);
    chk("abort_last_dout", {28'd0, dout}, 32'h6);
    idle_step();

    // Reset in cycle 3 of a transmit
    step(1'b1, 1'b0, 1'b0, 4'b1011, 1'b0);
    idle_step();
    idle_step();
    reset_step();
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_so", {31'd0, serial_out}, 32'd0);
    chk("rst_mid_sv", {31'd0, serial_valid}, 32'd0);
    chk("rst_mid_dout", {28'd0, dout}, 32'd0);
    pat = 4'b0110;
    step(1'b1, 1'b0, 1'b0, 4'b0110, 1'b0);
    for (int k = 1; k <= W; k++) begin
      chk("rst_after_so", {31'd0, serial_out}, {31'd0, pat[W-k]});
      idle_step();
    end
    chk("rst_after_done", {31'd0, done}, 32'd1);
    idle_step();

    // Back-to-back: receive 1,0,0,1 then transmit 0101
    rxbits = 4'b1001;
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 1; k <= W; k++) step(1'b0, 1'b0, 1'b0, '0, rxbits[W-k]);
    chk("b2b_rx_done", {31'd0, done}, 32'd1);
    chk("b2b_rx_dout", {28'd0, dout}, 32'h9);
    idle_step();
    pat = 4'b0101;
    step(1'b1, 1'b0, 1'b0, 4'b0101, 1'b0);
    for (int k = 1; k <= W; k++) begin
      chk("b2b_tx_so", {31'd0, serial_out}, {31'd0, pat[W-k]});
      idle_step();
    end
    chk("b2b_tx_done", {31'd0, done}, 32'd1);
    chk("b2b_tx_dout", {28'd0, dout}, 32'h9);
    idle_step();
    idle_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
